// File: rtl/oq_sram_pkg.sv
// Shared types and constants for the output-queue SRAM arbiter.
//   state_t         : arbiter FSM states (TURN only reachable with OQ_SRAM_TURNAROUND_EN)
//   side_t          : grant-side encoding (which requester was served last)
//   SRAM_WORD_WIDTH : default {ctrl,data} word width
//   BURST_W         : width of the burst counter (MAX_BURST up to 255)
package oq_sram_pkg;

   localparam int unsigned DATA_WIDTH_DFLT = 64;
   localparam int unsigned CTRL_WIDTH_DFLT = DATA_WIDTH_DFLT / 8;
   localparam int unsigned SRAM_WORD_WIDTH = DATA_WIDTH_DFLT + CTRL_WIDTH_DFLT;
   localparam int unsigned BURST_W         = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_TURN = 2'd3
   } state_t;

   typedef enum logic {
      SIDE_RD = 1'b0,
      SIDE_WR = 1'b1
   } side_t;

   // Side that should be served next when both sides compete.
   function automatic side_t other_side(input side_t s);
      return (s == SIDE_WR) ? SIDE_RD : SIDE_WR;
   endfunction

endpackage

// File: rtl/oq_sram_rd_pipe.sv
// Read-return pipeline: a RD_LATENCY+1 stage valid shift register tagged when a
// read is granted, plus the registered capture of SRAM read data.
//   clk, reset    : clock, async active-low reset (clears all in-flight tags)
//   issue         : read granted this cycle
//   sram_rd_data  : raw SRAM read data
//   rd_data       : captured read word, holds when rd_vld is low
//   rd_vld        : high exactly RD_LATENCY+1 cycles after the issue cycle
module oq_sram_rd_pipe #(
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned WORD_W     = 72
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue,
   input  logic [WORD_W-1:0] sram_rd_data,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_vld
);

   logic [RD_LATENCY:0] vld_sr;

   // Stage k is high k+1 cycles after issue; the last stage is the output strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_sr <= '0;
      end else begin
         vld_sr <= {vld_sr[RD_LATENCY-1:0], issue};
      end
   end

   assign rd_vld = vld_sr[RD_LATENCY];

   // SRAM data for a tagged read is on the pins while the previous stage is set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else if (vld_sr[RD_LATENCY-1]) begin
         rd_data <= sram_rd_data;
      end
   end

endmodule

// File: rtl/oq_sram_arbiter.sv
// Output-queue SRAM arbiter: responder for the packet-store write path (wr_0_*)
// and packet-remove read path (rd_0_*), driving one synchronous pipelined
// single-port SRAM. Grants alternate in bounded bursts of up to MAX_BURST while
// the other side waits; read data returns with a fixed-latency valid strobe.
// Optional macro OQ_SRAM_TURNAROUND_EN inserts one dead TURN cycle on every
// direct WR<->RD switch.
//   clk, reset          : clock, async active-low reset
//   wr_0_req/addr/data  : write request (held until acked), address, {ctrl,data}
//   wr_0_ack            : grant pulse, current write word consumed
//   rd_0_req/addr       : read request (held until acked), address
//   rd_0_ack            : grant pulse, current read address consumed
//   rd_0_data/vld       : read word and its valid strobe
//   sram_addr/we/wr_data: registered SRAM command
//   sram_rd_data        : SRAM read data
//   sram_tri_en         : data pin drive enable, equal to sram_we
module oq_sram_arbiter
   import oq_sram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DFLT,
   parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int unsigned SRAM_ADDR_WIDTH = 19,
   parameter int unsigned RD_LATENCY      = 2,
   parameter int unsigned MAX_BURST       = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [SRAM_ADDR_WIDTH-1:0]      wr_0_addr,
   input  logic                            wr_0_req,
   output logic                            wr_0_ack,
   input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] wr_0_data,
   input  logic [SRAM_ADDR_WIDTH-1:0]      rd_0_addr,
   input  logic                            rd_0_req,
   output logic                            rd_0_ack,
   output logic [DATA_WIDTH+CTRL_WIDTH-1:0] rd_0_data,
   output logic                            rd_0_vld,
   output logic [SRAM_ADDR_WIDTH-1:0]      sram_addr,
   output logic                            sram_we,
   output logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_wr_data,
   input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_rd_data,
   output logic                            sram_tri_en
);

   localparam int unsigned        WORD_W    = DATA_WIDTH + CTRL_WIDTH;
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

`ifdef OQ_SRAM_TURNAROUND_EN
   localparam bit TURN_EN = 1'b1;
`else
   localparam bit TURN_EN = 1'b0;
`endif

   state_t             state, state_nxt;
   side_t              last_grant, last_grant_nxt;
   logic [BURST_W-1:0] burst_cnt, burst_nxt;
   logic               wr_grant_c, rd_grant_c;

   function automatic state_t side_state(input side_t s);
      return (s == SIDE_WR) ? ST_WR : ST_RD;
   endfunction

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         last_grant <= SIDE_RD;
         burst_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         burst_cnt  <= burst_nxt;
      end
   end

   // Next state, grants, burst accounting
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      burst_nxt      = burst_cnt;
      wr_grant_c     = 1'b0;
      rd_grant_c     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (wr_0_req && rd_0_req) begin
               state_nxt = side_state(other_side(last_grant));
            end else if (wr_0_req) begin
               state_nxt = ST_WR;
            end else if (rd_0_req) begin
               state_nxt = ST_RD;
            end
         end
         ST_WR: begin
            wr_grant_c = wr_0_req;
            if (wr_0_req && (!rd_0_req || (burst_cnt < BURST_MAX))) begin
               state_nxt = ST_WR;
            end else if (rd_0_req) begin
               state_nxt = TURN_EN ? ST_TURN : ST_RD;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RD: begin
            rd_grant_c = rd_0_req;
            if (rd_0_req && (!wr_0_req || (burst_cnt < BURST_MAX))) begin
               state_nxt = ST_RD;
            end else if (wr_0_req) begin
               state_nxt = TURN_EN ? ST_TURN : ST_WR;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_TURN: begin
            // Head for the side that was not served last
            if (last_grant == SIDE_WR) begin
               state_nxt = rd_0_req ? ST_RD : ST_IDLE;
            end else begin
               state_nxt = wr_0_req ? ST_WR : ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (wr_grant_c) begin
         last_grant_nxt = SIDE_WR;
      end else if (rd_grant_c) begin
         last_grant_nxt = SIDE_RD;
      end

      // A new run starts at 1 on entry to a side (or TURN); TURN->side keeps it
      if ((state_nxt == ST_TURN) ||
          ((state_nxt != state) && (state_nxt != ST_IDLE) && (state != ST_TURN))) begin
         burst_nxt = BURST_W'(1);
      end else if ((wr_grant_c || rd_grant_c) && (burst_cnt < BURST_MAX)) begin
         burst_nxt = burst_cnt + BURST_W'(1);
      end
   end

   assign wr_0_ack = wr_grant_c;
   assign rd_0_ack = rd_grant_c;

   // SRAM command register: one cycle after the grant
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sram_addr    <= '0;
         sram_we      <= 1'b0;
         sram_tri_en  <= 1'b0;
         sram_wr_data <= '0;
      end else begin
         sram_we     <= wr_grant_c;
         sram_tri_en <= wr_grant_c;
         if (wr_grant_c) begin
            sram_addr    <= wr_0_addr;
            sram_wr_data <= wr_0_data;
         end else if (rd_grant_c) begin
            sram_addr <= rd_0_addr;
         end
      end
   end

   oq_sram_rd_pipe #(
      .RD_LATENCY (RD_LATENCY),
      .WORD_W     (WORD_W)
   ) u_rd_pipe (
      .clk          (clk),
      .reset        (reset),
      .issue        (rd_grant_c),
      .sram_rd_data (sram_rd_data),
      .rd_data      (rd_0_data),
      .rd_vld       (rd_0_vld)
   );

endmodule

// File: tb/tb_oq_sram_arbiter.sv
// Self-checking bench for oq_sram_arbiter with a behavioural pipelined SRAM
// (RD_LATENCY=2) and a read scoreboard.
module tb_oq_sram_arbiter;

   localparam int unsigned AW  = 19;
   localparam int unsigned WW  = oq_sram_pkg::SRAM_WORD_WIDTH;
   localparam int          LAT = 2;
   localparam int          MB  = 8;
`ifdef OQ_SRAM_TURNAROUND_EN
   localparam int TURN_CYC = 1;
`else
   localparam int TURN_CYC = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] wr_0_addr, rd_0_addr, sram_addr;
   logic          wr_0_req, wr_0_ack, rd_0_req, rd_0_ack, rd_0_vld;
   logic [WW-1:0] wr_0_data, rd_0_data, sram_wr_data;
   logic [WW-1:0] sram_rd_data = '0;
   logic          sram_we, sram_tri_en;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int vld_cnt  = 0;

   oq_sram_arbiter #(
      .DATA_WIDTH      (64),
      .CTRL_WIDTH      (8),
      .SRAM_ADDR_WIDTH (AW),
      .RD_LATENCY      (LAT),
      .MAX_BURST       (MB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_0_addr    (wr_0_addr),
      .wr_0_req     (wr_0_req),
      .wr_0_ack     (wr_0_ack),
      .wr_0_data    (wr_0_data),
      .rd_0_addr    (rd_0_addr),
      .rd_0_req     (rd_0_req),
      .rd_0_ack     (rd_0_ack),
      .rd_0_data    (rd_0_data),
      .rd_0_vld     (rd_0_vld),
      .sram_addr    (sram_addr),
      .sram_we      (sram_we),
      .sram_wr_data (sram_wr_data),
      .sram_rd_data (sram_rd_data),
      .sram_tri_en  (sram_tri_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [WW-1:0] init_word(input logic [AW-1:0] a);
      return {8'hC3, 45'h0, a};
   endfunction

   // SRAM model: data for the address seen in cycle c appears in cycle c+LAT-1
   logic [WW-1:0] sram_mem [int];
   always @(posedge clk) begin
      if (sram_mem.exists(int'(sram_addr))) sram_rd_data <= sram_mem[int'(sram_addr)];
      else                                  sram_rd_data <= init_word(sram_addr);
      if (sram_we) sram_mem[int'(sram_addr)] = sram_wr_data;
   end

   // Reference memory and scoreboard
   logic [WW-1:0] ref_mem [int];
   logic [WW-1:0] exp_data_q [$];
   int            exp_cyc_q  [$];
   bit            grant_side_q [$];
   int            grant_cyc_q  [$];

   function automatic logic [WW-1:0] ref_read(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
   endfunction

   bit            prev_wr, prev_rd;
   logic [AW-1:0] prev_addr;
   logic [WW-1:0] prev_data;
   logic [WW-1:0] pop_d;
   int            pop_c;

   // Monitor: sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         exp_data_q.delete();
         exp_cyc_q.delete();
         prev_wr = 1'b0;
         prev_rd = 1'b0;
      end else begin
         chk("sram_we", WW'(sram_we), WW'(prev_wr));
         chk("sram_tri_en", WW'(sram_tri_en), WW'(prev_wr));
         if (prev_wr || prev_rd) chk("sram_addr", WW'(sram_addr), WW'(prev_addr));
         if (prev_wr) chk("sram_wr_data", sram_wr_data, prev_data);
         chk("ack_excl", WW'(wr_0_ack & rd_0_ack), '0);
         if (rd_0_vld) begin
            vld_cnt++;
            if (exp_data_q.size() == 0) begin
               chk("rd_vld_spurious", WW'(1'b1), WW'(1'b0));
            end else begin
               pop_d = exp_data_q.pop_front();
               pop_c = exp_cyc_q.pop_front();
               chk("rd_data", rd_0_data, pop_d);
               chk("rd_latency", WW'(cyc - pop_c), WW'(LAT + 1));
            end
         end
         if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0] + LAT + 1) begin
            chk("rd_missing", WW'(1'b0), WW'(1'b1));
            void'(exp_data_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
         prev_wr   = wr_0_ack;
         prev_rd   = rd_0_ack;
         prev_addr = wr_0_ack ? wr_0_addr : rd_0_addr;
         prev_data = wr_0_data;
         if (wr_0_ack) ref_mem[int'(wr_0_addr)] = wr_0_data;
         if (rd_0_ack) begin
            exp_data_q.push_back(ref_read(rd_0_addr));
            exp_cyc_q.push_back(cyc);
         end
         if (wr_0_ack || rd_0_ack) begin
            grant_side_q.push_back(wr_0_ack);
            grant_cyc_q.push_back(cyc);
         end
      end
   end

   // Drivers: called just after a rising edge, return just after the consuming edge
   task automatic wr_word(input logic [AW-1:0] a, input logic [WW-1:0] d, output int waited);
      bit got = 1'b0;
      waited    = 0;
      wr_0_req  = 1'b1;
      wr_0_addr = a;
      wr_0_data = d;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (wr_0_ack) begin got = 1'b1; break; end
         waited++;
      end
      if (!got) chk("wr_timeout", WW'(1'b0), WW'(1'b1));
      @(posedge clk); #1;
   endtask

   task automatic rd_word(input logic [AW-1:0] a, output int waited);
      bit got = 1'b0;
      waited    = 0;
      rd_0_req  = 1'b1;
      rd_0_addr = a;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (rd_0_ack) begin got = 1'b1; break; end
         waited++;
      end
      if (!got) chk("rd_timeout", WW'(1'b0), WW'(1'b1));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic outputs_zero(input string pfx);
      chk({pfx, "_ctl"}, WW'({wr_0_ack, rd_0_ack, rd_0_vld, sram_we, sram_tri_en}), '0);
      chk({pfx, "_rd_data"}, rd_0_data, '0);
      chk({pfx, "_sram_addr"}, WW'(sram_addr), '0);
      chk({pfx, "_wr_data"}, sram_wr_data, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   int w;
   int runs [$];
   bit run_side [$];
   int sw_gap [$];

   initial begin
      reset = 1'b0; wr_0_req = 1'b0; rd_0_req = 1'b0;
      wr_0_addr = '0; rd_0_addr = '0; wr_0_data = '0;
      repeat (3) @(posedge clk); #1;
      outputs_zero("rst");
      reset = 1'b1;

      // Single write right after reset release
      wr_word(19'h10, 72'hA5_A5A5_A5A5_A5A5_A5A5, w);
      wr_0_req = 1'b0;
      chk("t1_ack_lat", WW'(w), WW'(1));
      chk("t1_sram_we", WW'(sram_we), WW'(1'b1));
      chk("t1_sram_addr", WW'(sram_addr), WW'(19'h10));
      chk("t1_sram_wr_data", sram_wr_data, 72'hA5_A5A5_A5A5_A5A5_A5A5);
      idle(3);

      // Four back-to-back reads
      grant_cyc_q.delete(); grant_side_q.delete(); vld_cnt = 0;
      for (int i = 0; i < 4; i++) rd_word(AW'(32'h20 + i), w);
      rd_0_req = 1'b0;
      idle(8);
      chk("t2_ngrants", WW'(grant_cyc_q.size()), WW'(4));
      if (grant_cyc_q.size() == 4) chk("t2_b2b", WW'(grant_cyc_q[3] - grant_cyc_q[0]), WW'(3));
      chk("t2_vld_cnt", WW'(vld_cnt), WW'(4));

      // Write then read the same address
      fork
         begin wr_word(19'h7, 72'h5, w); wr_0_req = 1'b0; end
         begin rd_word(19'h7, w); rd_0_req = 1'b0; end
      join
      idle(8);
      chk("t4_rd_hold", rd_0_data, 72'h5);

      // Both sides saturated: runs of MAX_BURST
      grant_cyc_q.delete(); grant_side_q.delete();
      fork
         begin
            for (int i = 0; i < 20; i++) wr_word(AW'(32'h200 + i), WW'(64'hBEEF_0000 + i), w);
            wr_0_req = 1'b0;
         end
         begin
            for (int i = 0; i < 20; i++) rd_word(AW'(32'h100 + i), w);
            rd_0_req = 1'b0;
         end
      join
      idle(8);
      for (int i = 0; i < grant_side_q.size(); i++) begin
         if (i == 0 || grant_side_q[i] != grant_side_q[i-1]) begin
            runs.push_back(1);
            run_side.push_back(grant_side_q[i]);
            if (i > 0) sw_gap.push_back(grant_cyc_q[i] - grant_cyc_q[i-1]);
         end else begin
            runs[runs.size()-1]++;
         end
      end
      chk("t3_nruns", WW'(runs.size()), WW'(6));
      if (runs.size() == 6) begin
         chk("t3_first_side_wr", WW'(run_side[0]), WW'(1'b1));
         for (int i = 0; i < 4; i++) chk("t3_run_len", WW'(runs[i]), WW'(MB));
         chk("t3_tail_wr", WW'(runs[4]), WW'(4));
         chk("t3_tail_rd", WW'(runs[5]), WW'(4));
         for (int i = 0; i < 4; i++) chk("t3_burst_switch_gap", WW'(sw_gap[i]), WW'(1 + TURN_CYC));
         chk("t3_drop_switch_gap", WW'(sw_gap[4]), WW'(2 + TURN_CYC));
      end

      // Reset with two reads in flight
      rd_word(19'h30, w);
      rd_word(19'h31, w);
      rd_0_req = 1'b0;
      reset    = 1'b0;
      #1;
      outputs_zero("t5_rst");
      idle(3);
      reset   = 1'b1;
      vld_cnt = 0;
      idle(10);
      chk("t5_no_vld", WW'(vld_cnt), WW'(0));

      // Alternating single writes and reads
      grant_cyc_q.delete(); grant_side_q.delete();
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            wr_word(AW'(32'h40 + i), WW'(64'hCAFE_0000 + i), w);
            wr_0_req = 1'b0;
         end else begin
            rd_word(AW'(32'h40 + i - 1), w);
            rd_0_req = 1'b0;
         end
      end
      idle(8);
      chk("t6_ngrants", WW'(grant_side_q.size()), WW'(6));
      if (grant_side_q.size() == 6) begin
         for (int i = 0; i < 6; i++) chk("t6_side", WW'(grant_side_q[i]), WW'(i % 2 == 0));
         for (int i = 0; i < 5; i++) chk("t6_gap", WW'(grant_cyc_q[i+1] - grant_cyc_q[i]), WW'(2 + TURN_CYC));
      end

      chk("sb_empty", WW'(exp_data_q.size()), WW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/oq_sram_arbiter.md
Name: oq_sram_arbiter

Overview:
- Responder end of the output-queue SRAM request interface.
- Accepts word-granular write requests from the packet-store path (wr_0_*) and read requests from the packet-remove path (rd_0_*).
- Arbitrates between them with bounded bursts and drives one synchronous pipelined single-port SRAM.
- Returns read data with a fixed-latency valid strobe. Sits between the output-queue block and the SRAM pins.

Parameters:
- DATA_WIDTH, 64, datapath data bits.
- CTRL_WIDTH, DATA_WIDTH/8, control bits stored alongside data.
- SRAM_ADDR_WIDTH, 19, SRAM word address bits.
- RD_LATENCY, 2, SRAM cycles from address issue to read data on sram_rd_data (1..7).
- MAX_BURST, 8, max consecutive grants to one side while the other side is waiting (1..255).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- wr_0_addr  in  SRAM_ADDR_WIDTH  write word address.
- wr_0_req  in  1  write request; held until acked.
- wr_0_ack  out  1  one-cycle pulse; the current wr_0_addr/wr_0_data is consumed.
- wr_0_data  in  DATA_WIDTH+CTRL_WIDTH  write word, {ctrl,data}.
- rd_0_addr  in  SRAM_ADDR_WIDTH  read word address.
- rd_0_req  in  1  read request; held until acked.
- rd_0_ack  out  1  one-cycle pulse; the read address is consumed.
- rd_0_data  out  DATA_WIDTH+CTRL_WIDTH  read word.
- rd_0_vld  out  1  rd_0_data valid.
- sram_addr  out  SRAM_ADDR_WIDTH  registered SRAM address.
- sram_we  out  1  registered write enable, active-high.
- sram_wr_data  out  DATA_WIDTH+CTRL_WIDTH  registered write data.
- sram_rd_data  in  DATA_WIDTH+CTRL_WIDTH  SRAM read data.
- sram_tri_en  out  1  drive enable for SRAM data pins; equals sram_we.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, last_grant = RD, burst_cnt = 0, read-valid pipe cleared.
- Reset mid-operation: in-flight reads are discarded; no rd_0_vld is produced for them.
- Handshake:
  - A request is granted in the cycle its ack is high. The ack is combinationally derived from registered FSM state and the current req.
  - The requester may keep req high for back-to-back words; a new addr/data is sampled each ack.
  - At most one of wr_0_ack/rd_0_ack is high per cycle.
  - Throughput is one grant per cycle.
- FSM states: IDLE, WR, RD.
  - IDLE: if only one req, go to that side. If both, go opposite to last_grant.
  - WR (RD): ack the own side when its req is high.
  - Stay in WR (RD) while own req is high AND (other req low OR burst_cnt < MAX_BURST).
  - Otherwise switch to the other side if its req is high; else go to IDLE.
  - burst_cnt resets to 1 on a side switch, increments per grant, and saturates at MAX_BURST.
  - last_grant is updated on every grant.
- SRAM issue: on a grant, the next cycle has sram_addr = granted addr, and sram_we = 1 for a write. On a write, sram_wr_data = wr_0_data and sram_tri_en = 1. With no grant, sram_we = 0.
- Read return:
  - A RD_LATENCY+1 stage valid shift register is tagged at issue.
  - rd_0_vld is high exactly RD_LATENCY+1 cycles after the rd_0_ack cycle.
  - rd_0_data = sram_rd_data sampled in that cycle (registered). rd_0_data holds its last value when rd_0_vld = 0.
  - Read order equals issue order. There is no backpressure on the read return.
- Write-then-read to the same address in consecutive grants returns the new data (SRAM write-through semantics). The block adds no forwarding.
- Addresses pass through unchanged; no wrap arithmetic here.

Optional Feature:
- Macro: OQ_SRAM_TURNAROUND_EN.
- Defined: adds state TURN. Any RD->WR switch, and any WR->RD switch, passes through one TURN cycle with no grant and sram_we = 0, to avoid bus contention on non-ZBT parts. burst_cnt is unaffected in TURN.
- Undefined: switches happen with zero idle cycles, as described above.

Decomposition:
- Shared package oq_sram_pkg holds:
  - the state enum {IDLE, WR, RD, TURN};
  - localparam SRAM_WORD_WIDTH = DATA_WIDTH+CTRL_WIDTH;
  - the grant-side encoding.
- One sub-module, oq_sram_rd_pipe: the parameterised valid/data return pipeline of depth RD_LATENCY+1.

Test Plan:
- Reset release, wr_0_req=1, wr_0_addr=0x10, data=0xA5..: wr_0_ack next cycle, sram_we=1, sram_addr=0x10 one cycle later.
- rd_0_req held for 4 words at addr 0x20..0x23, RD_LATENCY=2: four consecutive acks; rd_0_vld high for 4 cycles starting 3 cycles after the first ack, with data in order.
- Both reqs continuously high, MAX_BURST=8: grants alternate in runs of exactly 8; no side starves.
- Write 0x5 to addr 0x7, then read addr 0x7: rd_0_data = 0x5 with rd_0_vld.
- Assert reset (0) with 2 reads in flight: outputs go to 0 immediately; no rd_0_vld after release.
- OQ_SRAM_TURNAROUND_EN defined, alternating single wr/rd reqs: exactly one idle cycle (no ack, sram_we=0) between each switch.
